// File: rtl/ml_stage_pkg.sv
// Shared types and helpers for the folded vector-by-scalar scale stage.
// Used by the RTL and by the bench so both agree on beat count and clamp limits.
package ml_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    longint lo;
    longint hi;
  } bounds_t;

  function automatic int beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  // Representable range of an out_w-bit result, signed or unsigned.
  function automatic bounds_t sat_bounds(input int out_w, input bit is_signed);
    bounds_t b;
    if (is_signed) begin
      b.hi = (longint'(1) <<< (out_w - 1)) - 1;
      b.lo = -(longint'(1) <<< (out_w - 1));
    end else begin
      b.hi = (longint'(1) << out_w) - 1;
      b.lo = 0;
    end
    return b;
  endfunction

endpackage

// File: rtl/ml_scale_stage_if.sv
// Valid/ready bundle of the scale stage: vector+scale in, result vector out.
interface ml_scale_stage_if #(
  parameter int N_CH  = 10,
  parameter int A_W   = 8,
  parameter int S_W   = 6,
  parameter int OUT_W = 14
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N_CH*A_W-1:0]     in_data;
  logic [S_W-1:0]          in_scale;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_CH*OUT_W-1:0]   out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_data, in_scale, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_scale, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/ml_scale_lane.sv
// One combinational multiplier lane: element times scale, then extend,
// clamp or truncate to OUT_W bits depending on the configured width rule.
module ml_scale_lane
  import ml_stage_pkg::*;
#(
  parameter int A_W    = 8,
  parameter int S_W    = 6,
  parameter int OUT_W  = 14,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic [A_W-1:0]   a_i,
  input  logic [S_W-1:0]   s_i,
  output logic [OUT_W-1:0] r_o,
  output logic             clamp_o
);

  localparam int P_W = A_W + S_W;
  localparam int PX  = P_W + 2;

  logic signed [A_W:0] a_x;
  logic signed [S_W:0] s_x;

  // One extra bit lets unsigned operands live in a signed multiply.
  assign a_x = {(SIGNED != 0) & a_i[A_W-1], a_i};
  assign s_x = {(SIGNED != 0) & s_i[S_W-1], s_i};

  if (OUT_W >= P_W) begin : g_ext
    assign r_o     = OUT_W'(a_x) * OUT_W'(s_x);
    assign clamp_o = 1'b0;
  end else if (SAT != 0) begin : g_sat
    localparam bounds_t B = sat_bounds(OUT_W, SIGNED != 0);
    localparam logic signed [PX-1:0] HI = PX'(B.hi);
    localparam logic signed [PX-1:0] LO = PX'(B.lo);
    logic signed [PX-1:0] prod;

    assign prod = PX'(a_x) * PX'(s_x);

    always_comb begin
      r_o     = prod[OUT_W-1:0];
      clamp_o = 1'b0;
      if (prod > HI) begin
        r_o     = OUT_W'(HI);
        clamp_o = 1'b1;
      end else if (prod < LO) begin
        r_o     = OUT_W'(LO);
        clamp_o = 1'b1;
      end
    end
  end else begin : g_wrap
    assign r_o     = OUT_W'(a_x) * OUT_W'(s_x);
    assign clamp_o = 1'b0;
  end

endmodule

// File: rtl/ml_scale_stage.sv
// Folded vector-by-scalar multiply: LANES shared multipliers sweep the latched
// vector over BEATS cycles, then the full result is held until accepted.
module ml_scale_stage
  import ml_stage_pkg::*;
#(
  parameter int N_CH   = 10,
  parameter int A_W    = 8,
  parameter int S_W    = 6,
  parameter int OUT_W  = 14,
  parameter int LANES  = 2,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input logic clk,
  input logic rst,
  ml_scale_stage_if.slave bus
);

  localparam int BEATS = beats(N_CH, LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [1:0]    S_IDLE    = ST_IDLE;
  localparam logic [1:0]    S_RUN     = ST_RUN;
  localparam logic [1:0]    S_DONE    = ST_DONE;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [1:0]            state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [N_CH*A_W-1:0]   a_q, a_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [N_CH*OUT_W-1:0] res_q, res_d;
  logic                  sat_q, sat_d;
  logic                  accept;

  int               lane_idx [LANES];
  logic [A_W-1:0]   lane_a   [LANES];
  logic [OUT_W-1:0] lane_r   [LANES];
  logic [LANES-1:0] lane_c;
  logic [LANES-1:0] lane_act;

  assign bus.in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = res_q;
  assign bus.out_sat   = sat_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // Lanes past the last element on the final beat see zero and write nothing.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_idx[k] = int'(beat_q) * LANES + k;
      lane_act[k] = (lane_idx[k] < N_CH);
      lane_a[k]   = lane_act[k] ? a_q[lane_idx[k]*A_W +: A_W] : '0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ml_scale_lane #(
      .A_W(A_W), .S_W(S_W), .OUT_W(OUT_W), .SIGNED(SIGNED), .SAT(SAT)
    ) u_lane (
      .a_i     (lane_a[k]),
      .s_i     (s_q),
      .r_o     (lane_r[k]),
      .clamp_o (lane_c[k])
    );
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    s_d     = s_q;
    res_d   = res_q;
    sat_d   = sat_q;
    case (state_q)
      S_RUN: begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_act[k]) res_d[lane_idx[k]*OUT_W +: OUT_W] = lane_r[k];
        end
        sat_d = sat_q | (|(lane_c & lane_act));
        if (beat_q == LAST_BEAT) begin
          state_d = S_DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A DONE->RUN accept overrides the DONE exit on the same edge.
    if (accept) begin
      a_d     = bus.in_data;
      s_d     = bus.in_scale;
      beat_d  = '0;
      sat_d   = 1'b0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      a_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      s_q     <= s_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

endmodule
